ddr_rd_engine: RTL and testbench

//  Read-side engine behind the DDR local queue. Accepts one read descriptor (addr, len in 8-byte beats, last-beat strb).

---
 rtl/ddr_rd_engine.sv | 215 +++++++++++++++++++++
 tb/tb_ddr_rd_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_engine.sv
// ddr_rd_engine: one read descriptor -> AXI4 INCR read bursts -> one AXIS packet.
// Optional build macro DDR_RD_SKID_EN adds a 2-entry skid buffer between R and AXIS.
// Ports: i_clk/i_rst_n (async active-low); i_rd_ddr_* descriptor in,
//   o_rd_ddr_ready idle/accept, o_rd_ddr_cpl done pulse; o_m_axi_ar*/i_m_axi_r*
//   AXI4 read master; o_m_axis_* packet out; o_rd_err sticky response error.
module ddr_rd_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int P_MAX_BURST_LEN    = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_rd_ddr_addr,
  input  logic [15:0]                     i_rd_ddr_len,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_rd_ddr_strb,
  input  logic                            i_rd_ddr_valid,
  output logic                            o_rd_ddr_ready,
  output logic                            o_rd_ddr_cpl,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   o_m_axi_araddr,
  output logic [7:0]                      o_m_axi_arlen,
  output logic [2:0]                      o_m_axi_arsize,
  output logic [1:0]                      o_m_axi_arburst,
  output logic                            o_m_axi_arvalid,
  input  logic                            i_m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_m_axi_rdata,
  input  logic [1:0]                      i_m_axi_rresp,
  input  logic                            i_m_axi_rlast,
  input  logic                            i_m_axi_rvalid,
  output logic                            o_m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_m_axis_tdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] o_m_axis_tkeep,
  output logic                            o_m_axis_tlast,
  output logic                            o_m_axis_tvalid,
  input  logic                            i_m_axis_tready,
  output logic                            o_rd_err
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int KW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_DATA,
    S_CPL
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [15:0]   rem_q;
  logic [15:0]   rem_nx;
  logic [KW-1:0] strb_q;
  logic [8:0]    burst_q;
  logic [8:0]    bcnt_q;
  logic [8:0]    burst_c;
  logic [9:0]    b4k;
  logic          err_q;
  logic          rdy_q;
  logic          accept;
  logic          ar_hs;
  logic          r_hs;
  logic          live;
  logic          fin;
  logic          bad;
  logic          in_data;

  assign in_data = state_q == S_DATA;
  assign accept  = i_rd_ddr_valid & rdy_q;
  assign ar_hs   = o_m_axi_arvalid & i_m_axi_arready;
  assign r_hs    = i_m_axi_rvalid & o_m_axi_rready;
  assign live    = bcnt_q != 9'd0;
  assign fin     = rem_q == 16'd1;
  assign rem_nx  = live ? rem_q - 16'd1 : rem_q;

  // error: non-OKAY response, beat past the burst count, or short burst
  assign bad = (i_m_axi_rresp != 2'b00) | ~live
             | (i_m_axi_rlast & (bcnt_q != 9'd1));

  // beats left before the next 4 KB page (1..512)
  assign b4k = 10'd512 - {1'b0, addr_q[11:3]};

  always_comb begin
    burst_c = (rem_q > 16'(P_MAX_BURST_LEN))
            ? 9'(P_MAX_BURST_LEN) : rem_q[8:0];
    if ({1'b0, burst_c} > b4k) burst_c = b4k[8:0];
  end

  assign o_rd_ddr_ready  = rdy_q;
  assign o_rd_ddr_cpl    = state_q == S_CPL;
  assign o_m_axi_arvalid = state_q == S_AR;
  assign o_m_axi_araddr  = o_m_axi_arvalid ? addr_q : '0;
  assign o_m_axi_arlen   = o_m_axi_arvalid ? 8'(burst_c - 9'd1) : 8'd0;
  assign o_m_axi_arsize  = 3'b011;
  assign o_m_axi_arburst = 2'b01;
  assign o_rd_err        = err_q;

`ifdef DDR_RD_SKID_EN
  logic [DW-1:0] sk_d [2];
  logic [KW-1:0] sk_k [2];
  logic [1:0]    sk_l;
  logic          sk_wr;
  logic          sk_rd;
  logic [1:0]    sk_cnt;
  logic          done_q;
  logic          push;
  logic          pop;

  assign o_m_axi_rready = in_data & ~done_q & (~live | (sk_cnt != 2'd2));
  assign push = r_hs & live;
  assign o_m_axis_tvalid = sk_cnt != 2'd0;
  assign pop = o_m_axis_tvalid & i_m_axis_tready;
  assign o_m_axis_tdata = o_m_axis_tvalid ? sk_d[sk_rd] : '0;
  assign o_m_axis_tkeep = o_m_axis_tvalid ? sk_k[sk_rd] : '0;
  assign o_m_axis_tlast = o_m_axis_tvalid & sk_l[sk_rd];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sk_d   <= '{default: '0};
      sk_k   <= '{default: '0};
      sk_l   <= 2'b00;
      sk_wr  <= 1'b0;
      sk_rd  <= 1'b0;
      sk_cnt <= 2'd0;
      done_q <= 1'b0;
    end else begin
      if (push) begin
        sk_d[sk_wr] <= i_m_axi_rdata;
        sk_k[sk_wr] <= fin ? strb_q : '1;
        sk_l[sk_wr] <= fin;
        sk_wr       <= ~sk_wr;
      end
      if (pop) sk_rd <= ~sk_rd;
      unique case ({push, pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
      if (accept) done_q <= 1'b0;
      else if (r_hs & i_m_axi_rlast & (rem_nx == 16'd0)) done_q <= 1'b1;
    end
  end
`else
  logic tv;

  assign tv = in_data & live & i_m_axi_rvalid;
  assign o_m_axi_rready  = in_data & (live ? i_m_axis_tready : 1'b1);
  assign o_m_axis_tvalid = tv;
  assign o_m_axis_tdata  = tv ? i_m_axi_rdata : '0;
  assign o_m_axis_tkeep  = tv ? (fin ? strb_q : '1) : '0;
  assign o_m_axis_tlast  = tv & fin;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (i_rd_ddr_len == 16'd0) ? S_CPL : S_AR;
      end
      S_AR: begin
        if (i_m_axi_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (r_hs & i_m_axi_rlast) begin
          if (rem_nx != 16'd0) state_d = S_AR;
`ifndef DDR_RD_SKID_EN
          else state_d = S_CPL;
`endif
        end
`ifdef DDR_RD_SKID_EN
        if (done_q & (sk_cnt == 2'd0)) state_d = S_CPL;
`endif
      end
      S_CPL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      addr_q  <= '0;
      rem_q   <= 16'd0;
      strb_q  <= '0;
      burst_q <= 9'd0;
      bcnt_q  <= 9'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d == S_IDLE;
      if (accept) begin
        addr_q <= i_rd_ddr_addr;
        rem_q  <= i_rd_ddr_len;
        strb_q <= i_rd_ddr_strb;
      end
      if (ar_hs) begin
        burst_q <= burst_c;
        bcnt_q  <= burst_c;
      end
      if (r_hs) begin
        rem_q <= rem_nx;
        if (live) bcnt_q <= bcnt_q - 9'd1;
        if (bad) err_q <= 1'b1;
        if (i_m_axi_rlast) begin
          bcnt_q <= 9'd0;
          if (rem_nx != 16'd0)
            addr_q <= addr_q + AW'({burst_q, 3'b000});
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_rd_engine.sv
// tb_ddr_rd_engine: random DDR slave + AXIS sink checked against a
// queue-based model of burst splitting and packet contents.
module tb_ddr_rd_engine;

  localparam int MAXB = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_rd_ddr_addr = '0;
  logic [15:0] i_rd_ddr_len = '0;
  logic [7:0]  i_rd_ddr_strb = '0;
  logic        i_rd_ddr_valid = 1'b0;
  logic        o_rd_ddr_ready;
  logic        o_rd_ddr_cpl;
  logic [31:0] o_m_axi_araddr;
  logic [7:0]  o_m_axi_arlen;
  logic [2:0]  o_m_axi_arsize;
  logic [1:0]  o_m_axi_arburst;
  logic        o_m_axi_arvalid;
  logic        i_m_axi_arready = 1'b0;
  logic [63:0] i_m_axi_rdata = '0;
  logic [1:0]  i_m_axi_rresp = '0;
  logic        i_m_axi_rlast = 1'b0;
  logic        i_m_axi_rvalid = 1'b0;
  logic        o_m_axi_rready;
  logic [63:0] o_m_axis_tdata;
  logic [7:0]  o_m_axis_tkeep;
  logic        o_m_axis_tlast;
  logic        o_m_axis_tvalid;
  logic        i_m_axis_tready = 1'b0;
  logic        o_rd_err;

  always #5 i_clk = ~i_clk;

  ddr_rd_engine #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(64),
    .P_MAX_BURST_LEN(MAXB)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rd_ddr_addr(i_rd_ddr_addr), .i_rd_ddr_len(i_rd_ddr_len),
    .i_rd_ddr_strb(i_rd_ddr_strb), .i_rd_ddr_valid(i_rd_ddr_valid),
    .o_rd_ddr_ready(o_rd_ddr_ready), .o_rd_ddr_cpl(o_rd_ddr_cpl),
    .o_m_axi_araddr(o_m_axi_araddr), .o_m_axi_arlen(o_m_axi_arlen),
    .o_m_axi_arsize(o_m_axi_arsize), .o_m_axi_arburst(o_m_axi_arburst),
    .o_m_axi_arvalid(o_m_axi_arvalid), .i_m_axi_arready(i_m_axi_arready),
    .i_m_axi_rdata(i_m_axi_rdata), .i_m_axi_rresp(i_m_axi_rresp),
    .i_m_axi_rlast(i_m_axi_rlast), .i_m_axi_rvalid(i_m_axi_rvalid),
    .o_m_axi_rready(o_m_axi_rready),
    .o_m_axis_tdata(o_m_axis_tdata), .o_m_axis_tkeep(o_m_axis_tkeep),
    .o_m_axis_tlast(o_m_axis_tlast), .o_m_axis_tvalid(o_m_axis_tvalid),
    .i_m_axis_tready(i_m_axis_tready), .o_rd_err(o_rd_err)
  );

  typedef struct { logic [31:0] a; logic [7:0] l; } ar_t;
  typedef struct { logic [63:0] d; logic [7:0] k; logic l; } bt_t;

  ar_t plan_q[$];
  ar_t exp_ar[$];
  ar_t sl_q[$];
  bt_t exp_bt[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cpl_cnt = 0;
  int tlast_cnt = 0;
  int acc_cyc = 0;
  int acc_len = 0;
  int cur_len = 0;
  int last_bt_cyc = 0;
  int sl_beat = 0;
  int rbeat = 0;
  int err_beat = -1;
  int tr_mode = 0;
  logic err_model = 1'b0;
  logic cpl_prev = 1'b0;
  logic ar_hs_s = 1'b0;
  logic r_hs_s = 1'b0;
  logic [31:0] ar_a_s = '0;
  logic [7:0]  ar_l_s = '0;
  logic [7:0]  last_keep = '0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // bursts: min(remaining, MAXB, beats to 4 KB page end)
  function automatic void plan(input logic [31:0] a0, input int len);
    logic [31:0] a = a0;
    int r = len;
    int b;
    int b4;
    plan_q.delete();
    while (r > 0) begin
      b4 = (4096 - int'(a[11:0])) / 8;
      b = r;
      if (b > MAXB) b = MAXB;
      if (b > b4) b = b4;
      plan_q.push_back('{a, 8'(b - 1)});
      a = a + 32'(b * 8);
      r -= b;
    end
  endfunction

  always @(negedge i_clk) begin
    ar_t e;
    bt_t b;
    cyc++;
    if (!i_rst_n) begin
      ar_hs_s = 1'b0;
      r_hs_s = 1'b0;
      cpl_prev = 1'b0;
    end else begin
      chk("rd_err", o_rd_err, err_model);
      ar_hs_s = o_m_axi_arvalid & i_m_axi_arready;
      if (ar_hs_s) begin
        ar_a_s = o_m_axi_araddr;
        ar_l_s = o_m_axi_arlen;
        chk("arsize", o_m_axi_arsize, 3'b011);
        chk("arburst", o_m_axi_arburst, 2'b01);
        if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
        else begin
          e = exp_ar.pop_front();
          chk("araddr", o_m_axi_araddr, e.a);
          chk("arlen", o_m_axi_arlen, e.l);
        end
      end
      r_hs_s = i_m_axi_rvalid & o_m_axi_rready;
      if (r_hs_s && i_m_axi_rresp != 2'b00) err_model = 1'b1;
      if (o_m_axis_tvalid && i_m_axis_tready) begin
        last_bt_cyc = cyc;
        if (o_m_axis_tlast) begin
          tlast_cnt++;
          last_keep = o_m_axis_tkeep;
        end
        if (exp_bt.size() == 0) chk("beat_extra", 1, 0);
        else begin
          b = exp_bt.pop_front();
          chk("tdata", o_m_axis_tdata, b.d);
          chk("tkeep", o_m_axis_tkeep, b.k);
          chk("tlast", o_m_axis_tlast, b.l);
        end
      end
      if (i_rd_ddr_valid && o_rd_ddr_ready) begin
        acc_cyc = cyc;
        acc_len = cur_len;
      end
      if (o_rd_ddr_cpl) begin
        cpl_cnt++;
        chk("cpl_width", cpl_prev, 0);
        chk("cpl_beats_left", exp_bt.size(), 0);
        chk("cpl_ar_left", exp_ar.size(), 0);
        if (acc_len == 0) chk("cpl_lat0", cyc, acc_cyc + 1);
`ifdef DDR_RD_SKID_EN
        else chk("cpl_after_last", cyc > last_bt_cyc, 1);
`else
        else chk("cpl_lat", cyc, last_bt_cyc + 1);
`endif
      end
      cpl_prev = o_rd_ddr_cpl;
    end
  end

  // DDR slave: one burst queue, random AR/R stalls, R held until taken
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        sl_q.delete();
        sl_beat = 0;
        i_m_axi_arready = 1'b0;
        i_m_axi_rvalid = 1'b0;
        i_m_axi_rlast = 1'b0;
        i_m_axi_rresp = 2'b00;
      end else begin
        if (ar_hs_s) sl_q.push_back('{ar_a_s, ar_l_s});
        if (r_hs_s && sl_q.size() > 0) begin
          rbeat++;
          if (sl_beat == int'(sl_q[0].l)) begin
            void'(sl_q.pop_front());
            sl_beat = 0;
          end else sl_beat++;
        end
        i_m_axi_arready = $urandom_range(0, 2) != 0;
        if (i_m_axi_rvalid && !r_hs_s) begin
          i_m_axi_rvalid = 1'b1;
        end else if (sl_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          i_m_axi_rvalid = 1'b1;
          i_m_axi_rdata = mem_word(sl_q[0].a + 32'(8 * sl_beat));
          i_m_axi_rlast = sl_beat == int'(sl_q[0].l);
          i_m_axi_rresp = (rbeat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          i_m_axi_rvalid = 1'b0;
          i_m_axi_rlast = 1'b0;
          i_m_axi_rresp = 2'b00;
        end
      end
      case (tr_mode)
        0: i_m_axis_tready = 1'b1;
        1: i_m_axis_tready = ~i_m_axis_tready;
        default: i_m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic load(input logic [31:0] a, input int len,
                      input logic [7:0] s, input int mode, input int eb);
    tr_mode = mode;
    err_beat = eb;
    rbeat = 0;
    plan(a, len);
    foreach (plan_q[i]) exp_ar.push_back(plan_q[i]);
    for (int i = 0; i < len; i++)
      exp_bt.push_back('{mem_word(a + 32'(8 * i)),
                         (i == len - 1) ? s : 8'hFF, i == len - 1});
    cur_len = len;
  endtask

  task automatic issue(input logic [31:0] a, input int len,
                       input logic [7:0] s);
    int n = 0;
    while (!o_rd_ddr_ready && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("ready_before_issue", o_rd_ddr_ready, 1);
    i_rd_ddr_addr = a;
    i_rd_ddr_len = 16'(len);
    i_rd_ddr_strb = s;
    i_rd_ddr_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rd_ddr_valid = 1'b0;
    i_rd_ddr_addr = $urandom;
    i_rd_ddr_len = 16'($urandom);
    i_rd_ddr_strb = 8'($urandom);
  endtask

  task automatic run_desc(input logic [31:0] a, input int len,
                          input logic [7:0] s, input int mode, input int eb);
    int n = 0;
    int c0;
    load(a, len, s, mode, eb);
    issue(a, len, s);
    c0 = cpl_cnt;
    while (cpl_cnt == c0 && n < 4000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    n_cmp++;
    if (cpl_cnt == c0) begin
      n_bad++;
      $display("FAIL cpl_timeout: no cpl after %0d cycles, required 1", n);
    end
    exp_ar.delete();
    exp_bt.delete();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int t0;
    int n;
    int len;
    int eb;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", o_rd_ddr_ready, 0);
    chk("rst_cpl", o_rd_ddr_cpl, 0);
    chk("rst_arvalid", o_m_axi_arvalid, 0);
    chk("rst_araddr", o_m_axi_araddr, 0);
    chk("rst_arlen", o_m_axi_arlen, 0);
    chk("rst_arsize", o_m_axi_arsize, 3'b011);
    chk("rst_arburst", o_m_axi_arburst, 2'b01);
    chk("rst_rready", o_m_axi_rready, 0);
    chk("rst_tvalid", o_m_axis_tvalid, 0);
    chk("rst_tdata", o_m_axis_tdata, 0);
    chk("rst_tkeep", o_m_axis_tkeep, 0);
    chk("rst_tlast", o_m_axis_tlast, 0);
    chk("rst_err", o_rd_err, 0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("ready_after_rst", o_rd_ddr_ready, 1);

    plan(32'h1000, 4);
    chk("pin1_n", plan_q.size(), 1);
    chk("pin1_len", plan_q[0].l, 3);
    plan(32'h0, 40);
    chk("pin2_n", plan_q.size(), 3);
    chk("pin2_a1", plan_q[1].a, 32'h80);
    chk("pin2_a2", plan_q[2].a, 32'h100);
    chk("pin2_l0", plan_q[0].l, 15);
    chk("pin2_l2", plan_q[2].l, 7);
    plan(32'h0FF0, 8);
    chk("pin3_n", plan_q.size(), 2);
    chk("pin3_l0", plan_q[0].l, 1);
    chk("pin3_a1", plan_q[1].a, 32'h1000);
    chk("pin3_l1", plan_q[1].l, 5);

    run_desc(32'h1000, 4, 8'h0F, 0, -1);
    chk("t1_last_keep", last_keep, 8'h0F);
    t0 = tlast_cnt;
    run_desc(32'h0, 40, 8'hFF, 0, -1);
    chk("t2_one_tlast", tlast_cnt - t0, 1);
    run_desc(32'h0FF0, 8, 8'h3F, 0, -1);
    run_desc(32'h2000, 16, 8'h01, 1, -1);
    t0 = tlast_cnt;
    run_desc(32'h2400, 0, 8'hAA, 0, -1);
    chk("len0_no_tlast", tlast_cnt - t0, 0);
    chk("err_clean", o_rd_err, 0);
    run_desc(32'h3000, 8, 8'h7F, 0, 2);
    chk("err_set", o_rd_err, 1);
    run_desc(32'hFFFF_FFF0, 4, 8'hF0, 2, -1);
    chk("err_sticky", o_rd_err, 1);

    for (int i = 0; i < 10; i++) begin
      len = $urandom_range(0, 70);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : -1;
      run_desc(32'($urandom) & 32'hFFFF_FFF8, len,
               8'($urandom_range(1, 255)), 2, eb);
    end

    load(32'h5000, 32, 8'hFF, 0, -1);
    issue(32'h5000, 32, 8'hFF);
    n = 0;
    while (exp_bt.size() > 26 && n < 500) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("mid_data_reached", exp_bt.size() <= 26, 1);
    i_rst_n = 1'b0;
    err_model = 1'b0;
    exp_ar.delete();
    exp_bt.delete();
    #1;
    chk("mrst_rready", o_m_axi_rready, 0);
    chk("mrst_tvalid", o_m_axis_tvalid, 0);
    chk("mrst_arvalid", o_m_axi_arvalid, 0);
    chk("mrst_cpl", o_rd_ddr_cpl, 0);
    chk("mrst_err", o_rd_err, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("mrst_ready", o_rd_ddr_ready, 1);
    run_desc(32'h6000, 4, 8'h0F, 0, -1);
    chk("mrst_last_keep", last_keep, 8'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
